// File: rtl/add_nibble_seq.sv
// Sequential W-bit adder: one 4-bit adder stage reused once per nibble, LSB first,
// with a valid/ready handshake on both sides.
module add_nibble_seq #(
    parameter int NIB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              ci,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NIB-1:0]  s,
    output logic              co,
    output logic              busy
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_reg;
    logic [CW-1:0] cnt_reg;

    logic [3:0]    a_nib [NIB];
    logic [3:0]    b_nib [NIB];
    logic [4:0]    stage_sum;

    // Operand registers viewed as nibble arrays so the active nibble is a plain mux.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    // The single shared 4-bit adder stage.
    assign stage_sum = {1'b0, a_nib[cnt_reg]} + {1'b0, b_nib[cnt_reg]} + {4'b0, carry_reg};

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            s         <= '0;
            co        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ci;
                        cnt_reg   <= '0;
                        s         <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (cnt_reg == CW'(i)) begin
                            s[4*i +: 4] <= stage_sum[3:0];
                        end
                    end
                    carry_reg <= stage_sum[4];
                    // Counter stops at the last nibble rather than wrapping.
                    if (cnt_reg == LAST) begin
                        co        <= stage_sum[4];
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_nibble_seq.sv
// Randomized and directed bench for add_nibble_seq against an arithmetic reference.
module tb_add_nibble_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, ci, co, busy;
    logic [W-1:0] a, b, s;

    int total = 0;
    int bad   = 0;

    add_nibble_seq #(.NIB(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
        return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
    endfunction

    // Present one operand set, return after the accepting edge with operands scrambled.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        a = av; b = bv; ci = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 50);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (s !== '0) begin bad++; $display("FAIL reset_s got=%h exp=0000", s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL reset_co got=%0b exp=0", co); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: in_ready=%0b out_valid=%0b busy=%0b s=%h co=%0b", in_ready, out_valid, busy, s, co);
    endtask

    task automatic test_basic();
        int cyc;
        accept(16'h1234, 16'h4321, 1'b0);
        total++; if (s !== '0) begin bad++; $display("FAIL basic_s_cleared got=%h exp=0000", s); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%0b exp=0", in_ready); end
        wait_done(cyc);
        total++; if (cyc != NIB) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, NIB); end
        total++; if (s !== 16'h5555) begin bad++; $display("FAIL basic_s got=%h exp=5555", s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL basic_co got=%0b exp=0", co); end
        $display("basic: a=1234 b=4321 ci=0 s=%h co=%0b lat=%0d", s, co, cyc);
        release_out();
    endtask

    task automatic test_ripple();
        int cyc;
        accept(16'hFFFF, 16'h0000, 1'b1);
        wait_done(cyc);
        total++; if (cyc != NIB) begin bad++; $display("FAIL ripple_latency got=%0d exp=%0d", cyc, NIB); end
        total++; if (s !== 16'h0000) begin bad++; $display("FAIL ripple_s got=%h exp=0000", s); end
        total++; if (co !== 1'b1) begin bad++; $display("FAIL ripple_co got=%0b exp=1", co); end
        $display("ripple: a=FFFF b=0000 ci=1 s=%h co=%0b", s, co);
        release_out();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [W-1:0] held_s;
        accept(16'h8000, 16'h8000, 1'b0);
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            in_valid = (i == 2); a = 16'h1111; b = 16'h2222;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%0b exp=1", i, out_valid); end
            total++; if (s !== 16'h0000) begin bad++; $display("FAIL bp_s cyc=%0d got=%h exp=0000", i, s); end
            total++; if (co !== 1'b1) begin bad++; $display("FAIL bp_co cyc=%0d got=%0b exp=1", i, co); end
        end
        @(negedge clk); in_valid = 1'b0;
        held_s = s;
        $display("backpressure: s=%h co=%0b held 5 cycles", s, co);
        release_out();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%0b exp=1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (s !== 16'h0000 || co !== 1'b1) begin bad++; $display("FAIL idle_hold got s=%h co=%0b exp s=0000 co=1", s, co); end
    endtask

    task automatic test_reset_midop();
        int cyc;
        accept(16'hABCD, 16'h1357, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midop_out_valid cyc=%0d got=%0b exp=0", i, out_valid); end
        end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midop_idle got in_ready=%0b busy=%0b exp 1/0", in_ready, busy); end
        total++; if (s !== '0 || co !== 1'b0) begin bad++; $display("FAIL midop_clear got s=%h co=%0b exp 0000/0", s, co); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midop_after_out_valid cyc=%0d got=%0b exp=0", i, out_valid); end
        end
        accept(16'h0001, 16'h0001, 1'b0);
        wait_done(cyc);
        total++; if (cyc != NIB) begin bad++; $display("FAIL midop_latency got=%0d exp=%0d", cyc, NIB); end
        total++; if (s !== 16'h0002 || co !== 1'b0) begin bad++; $display("FAIL midop_result got s=%h co=%0b exp 0002/0", s, co); end
        $display("reset_midop: next op s=%h co=%0b", s, co);
        release_out();
    endtask

    task automatic test_back_to_back();
        int cyc;
        accept(16'h7777, 16'h1111, 1'b1);
        wait_done(cyc);
        total++; if (s !== 16'h8889 || co !== 1'b0) begin bad++; $display("FAIL b2b_first got s=%h co=%0b exp 8889/0", s, co); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
        a = 16'h0F0F; b = 16'h00F1; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%0b exp=1", busy); end
        @(negedge clk); in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
        wait_done(cyc);
        total++; if (cyc != NIB) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, NIB); end
        total++; if (s !== 16'h1000 || co !== 1'b0) begin bad++; $display("FAIL b2b_result got s=%h co=%0b exp 1000/0", s, co); end
        $display("back_to_back: a=0F0F b=00F1 s=%h co=%0b lat=%0d", s, co, cyc);
        release_out();
    endtask

    task automatic test_random();
        int cyc;
        logic [W-1:0] av, bv;
        logic cv;
        logic [W:0] exp_sum;
        for (int n = 0; n < 24; n++) begin
            av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
            if (n == 0) begin av = 16'hFFFF; bv = 16'hFFFF; cv = 1'b1; end
            exp_sum = model(av, bv, cv);
            accept(av, bv, cv);
            wait_done(cyc);
            total++; if (cyc != NIB) begin bad++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, cyc, NIB); end
            total++; if ({co, s} !== exp_sum) begin bad++; $display("FAIL rand_sum n=%0d got=%h exp=%h", n, {co, s}, exp_sum); end
            $display("random %0d: a=%h b=%h ci=%0b -> co=%0b s=%h exp=%h", n, av, bv, cv, co, s, exp_sum);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || {co, s} !== exp_sum) begin bad++; $display("FAIL rand_hold n=%0d got v=%0b %h exp v=1 %h", n, out_valid, {co, s}, exp_sum); end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
